// File: rtl/miner_pkg.sv
// Shared constants and helpers for the SHA256d mining front end.
package miner_pkg;

   localparam logic [31:0] SHA_PAD_WORD     = 32'h8000_0000;
   localparam logic [31:0] BTC_HDR_LEN_BITS = 32'h0000_0280;

   // word positions inside the 512-bit second block
   localparam int NONCE_WORD = 3;
   localparam int PAD_WORD   = 4;
   localparam int LEN_WORD   = 15;

   typedef enum logic {ST_IDLE, ST_RUN} ngen_state_t;

   function automatic logic [31:0] bswap32(input logic [31:0] x);
      return {x[7:0], x[15:8], x[23:16], x[31:24]};
   endfunction

endpackage

// File: rtl/miner_block2_fmt.sv
// Builds one padded second header block from the tail words and a nonce.
module miner_block2_fmt
   import miner_pkg::*;
#(
   parameter int NONCE_BSWAP = 1
) (
   input  logic [95:0]  tail,
   input  logic [31:0]  nonce,
   output logic [511:0] blk
);

   // word i lives at [511-32*i -: 32]; everything not written is zero
   always_comb begin
      blk = '0;
      blk[511 -: 96] = tail;
      blk[511-32*NONCE_WORD -: 32] = (NONCE_BSWAP != 0) ? bswap32(nonce) : nonce;
      blk[511-32*PAD_WORD -: 32]   = SHA_PAD_WORD;
      blk[511-32*LEN_WORD -: 32]   = BTC_HDR_LEN_BITS;
   end

endmodule

// File: rtl/miner_noncegen_blockgen.sv
// Job-driven nonce sweeper: emits NUM_LANES second blocks per beat until the
// nonce range is exhausted or the job is flushed.
module miner_noncegen_blockgen
   import miner_pkg::*;
#(
   parameter int NUM_LANES   = 4,
   parameter int NONCE_BSWAP = 1,
   parameter int JOB_ID_W    = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       job_valid,
   output logic                       job_ready,
   input  logic [JOB_ID_W-1:0]        job_id_i,
   input  logic [511:0]               block1_i,
   input  logic [95:0]                tail_i,
   input  logic [31:0]                nonce_start_i,
   input  logic [31:0]                nonce_end_i,
   input  logic                       flush,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [JOB_ID_W-1:0]        out_job_id,
   output logic [511:0]               block1_o,
   output logic [NUM_LANES*512-1:0]   block2_o,
   output logic [31:0]                nonce_base_o,
   output logic [NUM_LANES-1:0]       lane_mask_o,
   output logic                       job_done
);

   localparam logic [32:0] LANES33 = 33'(NUM_LANES);

   ngen_state_t                  state, state_nx;
   logic [31:0]                  base, nend;
   logic [95:0]                  tail_r;
   logic [511:0]                 blk1_r;
   logic [JOB_ID_W-1:0]          id_r;
   logic                         run, last, take_job;
   logic [NUM_LANES-1:0][511:0]  blk2;

   assign run      = (state == ST_RUN);
   assign take_job = job_valid && (state == ST_IDLE) && !flush;
   // 33-bit compare so a range ending at 0xFFFFFFFF cannot wrap into a second pass
   assign last     = ({1'b0, base} + LANES33 - 33'd1) >= {1'b0, nend};

   // state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_nx;
   end

   // next state and handshake outputs; flush overrides everything
   always_comb begin
      state_nx  = state;
      job_ready = 1'b0;
      out_valid = 1'b0;
      job_done  = 1'b0;
      case (state)
         ST_IDLE: begin
            job_ready = 1'b1;
            if (job_valid) state_nx = ST_RUN;
         end
         ST_RUN: begin
            out_valid = 1'b1;
            if (out_ready && last) begin
               job_done = !flush;
               state_nx = ST_IDLE;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
      if (flush) state_nx = ST_IDLE;
   end

   // job capture and nonce advance; all held while the consumer stalls
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         base   <= '0;
         nend   <= '0;
         tail_r <= '0;
         blk1_r <= '0;
         id_r   <= '0;
      end else if (take_job) begin
         base   <= nonce_start_i;
         nend   <= nonce_end_i;
         tail_r <= tail_i;
         blk1_r <= block1_i;
         id_r   <= job_id_i;
      end else if (run && out_ready && !last && !flush) begin
         base   <= base + 32'(NUM_LANES);
      end
   end

   for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
      logic [32:0] n;
      assign n = {1'b0, base} + 33'(k);
      assign lane_mask_o[k] = run && (n <= {1'b0, nend});
      miner_block2_fmt #(.NONCE_BSWAP(NONCE_BSWAP)) u_fmt (
         .tail  (tail_r),
         .nonce (n[31:0]),
         .blk   (blk2[k])
      );
   end

   // block 2 is only presented while a beat is live so idle/reset outputs read zero
   assign block2_o     = run ? blk2 : '0;
   assign block1_o     = blk1_r;
   assign out_job_id   = id_r;
   assign nonce_base_o = base;

endmodule

// File: tb/tb_miner_noncegen_blockgen.sv
// Directed bench for the multi-lane nonce/block generator.
module tb_miner_noncegen_blockgen;

   localparam int NL = 4;

   logic               clk = 1'b0;
   logic               rst = 1'b0;
   logic               job_valid = 1'b0;
   logic [7:0]         job_id_i = '0;
   logic [511:0]       block1_i = '0;
   logic [95:0]        tail_i = '0;
   logic [31:0]        nonce_start_i = '0;
   logic [31:0]        nonce_end_i = '0;
   logic               flush = 1'b0;
   logic               out_ready = 1'b0;

   logic               job_ready, out_valid, job_done;
   logic [7:0]         out_job_id;
   logic [511:0]       block1_o;
   logic [NL*512-1:0]  block2_o;
   logic [31:0]        nonce_base_o;
   logic [NL-1:0]      lane_mask_o;

   logic               b0_job_ready, b0_out_valid, b0_job_done;
   logic [7:0]         b0_out_job_id;
   logic [511:0]       b0_block1_o;
   logic [NL*512-1:0]  b0_block2_o;
   logic [31:0]        b0_nonce_base_o;
   logic [NL-1:0]      b0_lane_mask_o;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   miner_noncegen_blockgen #(.NUM_LANES(NL), .NONCE_BSWAP(1), .JOB_ID_W(8)) dut (
      .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(job_ready),
      .job_id_i(job_id_i), .block1_i(block1_i), .tail_i(tail_i),
      .nonce_start_i(nonce_start_i), .nonce_end_i(nonce_end_i), .flush(flush),
      .out_valid(out_valid), .out_ready(out_ready), .out_job_id(out_job_id),
      .block1_o(block1_o), .block2_o(block2_o), .nonce_base_o(nonce_base_o),
      .lane_mask_o(lane_mask_o), .job_done(job_done)
   );

   miner_noncegen_blockgen #(.NUM_LANES(NL), .NONCE_BSWAP(0), .JOB_ID_W(8)) dut0 (
      .clk(clk), .rst(rst), .job_valid(job_valid), .job_ready(b0_job_ready),
      .job_id_i(job_id_i), .block1_i(block1_i), .tail_i(tail_i),
      .nonce_start_i(nonce_start_i), .nonce_end_i(nonce_end_i), .flush(flush),
      .out_valid(b0_out_valid), .out_ready(out_ready), .out_job_id(b0_out_job_id),
      .block1_o(b0_block1_o), .block2_o(b0_block2_o), .nonce_base_o(b0_nonce_base_o),
      .lane_mask_o(b0_lane_mask_o), .job_done(b0_job_done)
   );

   typedef struct {
      logic [31:0] s;
      logic [31:0] e;
      int          nb;
      logic [3:0]  m_first;
      logic [3:0]  m_last;
      logic [7:0]  id;
   } vec_t;

   vec_t vecs[6];

   function automatic logic [31:0] swp(input logic [31:0] x);
      return {x[7:0], x[15:8], x[23:16], x[31:24]};
   endfunction

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_job(input logic [31:0] s, input logic [31:0] e, input logic [7:0] id,
                            input logic [95:0] t, input logic [511:0] b1);
      nonce_start_i = s;
      nonce_end_i   = e;
      job_id_i      = id;
      tail_i        = t;
      block1_i      = b1;
      job_valid     = 1'b1;
      chk("job_ready_idle", 128'(job_ready), 128'(1));
      tick();
      job_valid     = 1'b0;
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      logic [31:0]  bs;
      logic [3:0]   em;
      logic [511:0] b1;
      b1 = {16{32'hA5A5_0000 | 32'(idx)}};
      out_ready = 1'b1;
      start_job(v.s, v.e, v.id, 96'h0102_0304_0506_0708_090A_0B0C, b1);
      for (int b = 0; b < v.nb; b++) begin
         bs = v.s + 32'(4 * b);
         em = (b == 0) ? v.m_first : ((b == v.nb - 1) ? v.m_last : 4'hF);
         chk($sformatf("v%0d_b%0d_valid", idx, b), 128'(out_valid), 128'(1));
         chk($sformatf("v%0d_b%0d_base", idx, b), 128'(nonce_base_o), 128'(bs));
         chk($sformatf("v%0d_b%0d_mask", idx, b), 128'(lane_mask_o), 128'(em));
         chk($sformatf("v%0d_b%0d_done", idx, b), 128'(job_done), 128'(b == v.nb - 1));
         chk($sformatf("v%0d_b%0d_id", idx, b), 128'(out_job_id), 128'(v.id));
         for (int k = 0; k < NL; k++)
            chk($sformatf("v%0d_b%0d_l%0d_w3", idx, b, k),
                128'(block2_o[k*512+415 -: 32]), 128'(swp(bs + 32'(k))));
         if (b == 0) begin
            chk($sformatf("v%0d_blk1", idx), 128'(block1_o[127:0]), b1[127:0]);
            chk($sformatf("v%0d_tail", idx), 128'(block2_o[511 -: 96]), 128'(96'h0102_0304_0506_0708_090A_0B0C));
         end
         tick();
      end
      chk($sformatf("v%0d_end_valid", idx), 128'(out_valid), 128'(0));
      chk($sformatf("v%0d_end_ready", idx), 128'(job_ready), 128'(1));
      chk($sformatf("v%0d_end_done", idx), 128'(job_done), 128'(0));
   endtask

   initial begin
      vecs[0] = '{32'h10, 32'h1F, 4, 4'hF, 4'hF, 8'h01};
      vecs[1] = '{32'h10, 32'h12, 1, 4'b0111, 4'b0111, 8'h02};
      vecs[2] = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 1, 4'b0011, 4'b0011, 8'h03};
      vecs[3] = '{32'h20, 32'h10, 1, 4'h0, 4'h0, 8'h04};
      vecs[4] = '{32'h0, 32'h5, 2, 4'hF, 4'b0011, 8'h05};
      vecs[5] = '{32'hFFFF_FFF8, 32'hFFFF_FFFF, 2, 4'hF, 4'hF, 8'h06};

      // power-on reset
      #1 rst = 1'b1;
      #2;
      chk("rst_job_ready", 128'(job_ready), 128'(1));
      chk("rst_out_valid", 128'(out_valid), 128'(0));
      chk("rst_job_done", 128'(job_done), 128'(0));
      chk("rst_block2_zero", 128'(block2_o == '0), 128'(1));
      chk("rst_mask", 128'(lane_mask_o), 128'(0));
      chk("rst_base", 128'(nonce_base_o), 128'(0));
      tick(); tick();
      rst = 1'b0;
      tick();

      for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

      // explicit spot value: lane 2 of first beat of 0x10..0x1F
      out_ready = 1'b1;
      start_job(32'h10, 32'h1F, 8'h11, 96'h0, 512'h0);
      chk("spot_l2_w3", 128'(block2_o[2*512+415 -: 32]), 128'(32'h1200_0000));
      out_ready = 1'b0;
      flush = 1'b1;
      tick();
      flush = 1'b0;

      // stall for 5 cycles after the first beat
      out_ready = 1'b1;
      start_job(32'h100, 32'h10F, 8'h22, 96'h0, 512'h0);
      chk("stall_b0_base", 128'(nonce_base_o), 128'(32'h100));
      tick();
      out_ready = 1'b0;
      for (int c = 0; c < 5; c++) begin
         tick();
         chk($sformatf("stall_c%0d_base", c), 128'(nonce_base_o), 128'(32'h104));
         chk($sformatf("stall_c%0d_mask", c), 128'(lane_mask_o), 128'(4'hF));
         chk($sformatf("stall_c%0d_w3", c), 128'(block2_o[3*512+415 -: 32]), 128'(32'h0701_0000));
         chk($sformatf("stall_c%0d_valid", c), 128'(out_valid), 128'(1));
         chk($sformatf("stall_c%0d_done", c), 128'(job_done), 128'(0));
      end
      out_ready = 1'b1;
      for (int b = 1; b < 4; b++) begin
         chk($sformatf("resume_b%0d_base", b), 128'(nonce_base_o), 128'(32'h100 + 32'(4 * b)));
         chk($sformatf("resume_b%0d_done", b), 128'(job_done), 128'(b == 3));
         tick();
      end
      chk("resume_end_valid", 128'(out_valid), 128'(0));

      // flush during second beat
      start_job(32'h0, 32'hFF, 8'h55, 96'h0, 512'h0);
      tick();
      chk("flush_pre_base", 128'(nonce_base_o), 128'(32'h4));
      flush = 1'b1;
      chk("flush_no_done", 128'(job_done), 128'(0));
      tick();
      flush = 1'b0;
      chk("flush_valid", 128'(out_valid), 128'(0));
      chk("flush_ready", 128'(job_ready), 128'(1));
      // flush coincident with a job offer discards the job
      job_valid = 1'b1;
      flush = 1'b1;
      tick();
      job_valid = 1'b0;
      flush = 1'b0;
      chk("flush_job_discard", 128'(out_valid), 128'(0));
      start_job(32'h40, 32'h40, 8'h77, 96'h0, 512'h0);
      chk("newjob_id", 128'(out_job_id), 128'(8'h77));
      chk("newjob_base", 128'(nonce_base_o), 128'(32'h40));
      chk("newjob_mask", 128'(lane_mask_o), 128'(4'b0001));
      chk("newjob_done", 128'(job_done), 128'(1));
      tick();

      // raw-nonce layout, then reset mid-run
      out_ready = 1'b0;
      start_job(32'h1000, 32'h2000, 8'h33, 96'hAABBCCDD_11223344_55667788, {16{32'h1234_5678}});
      chk("raw_tail", 128'(b0_block2_o[512+511 -: 96]), 128'(96'hAABBCCDD_11223344_55667788));
      chk("raw_w3", 128'(b0_block2_o[512+415 -: 32]), 128'(32'h0000_1001));
      chk("raw_w4", 128'(b0_block2_o[512+383 -: 32]), 128'(32'h8000_0000));
      chk("raw_w15", 128'(b0_block2_o[512+31 -: 32]), 128'(32'h0000_0280));
      chk("raw_w5_14", 128'(b0_block2_o[512+351 -: 320] == '0), 128'(1));
      chk("swp_w3", 128'(block2_o[512+415 -: 32]), 128'(32'h0110_0000));
      #2 rst = 1'b1;
      #1;
      chk("midrst_valid", 128'(out_valid), 128'(0));
      chk("midrst_ready", 128'(job_ready), 128'(1));
      chk("midrst_done", 128'(job_done), 128'(0));
      chk("midrst_block2", 128'(block2_o == '0), 128'(1));
      chk("midrst_block1", 128'(block1_o == '0), 128'(1));
      chk("midrst_base", 128'(nonce_base_o), 128'(0));
      chk("midrst_mask", 128'(lane_mask_o), 128'(0));
      chk("midrst_id", 128'(out_job_id), 128'(0));
      tick();
      rst = 1'b0;
      tick();
      chk("postrst_valid", 128'(out_valid), 128'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/miner_noncegen_blockgen.md
Name: miner_noncegen_blockgen

Overview:
- Sequential, multi-lane successor to the fixed block generator.
- Accepts a mining job: the midstate-free first block, the 96-bit tail (merkle tail, ntime, nbits) and a nonce range.
- Emits NUM_LANES padded second blocks per beat, each with a distinct nonce inserted at word 3, over a valid/ready stream.
- Sits between the job interface and the SHA256d core array; advances the nonce by NUM_LANES per accepted beat until the range is exhausted or the job is flushed.

Parameters:
- NUM_LANES, 4, number of parallel second blocks per beat (1..16, power of two not required).
- NONCE_BSWAP, 1, 1 = byte-swap the nonce before placing it in word 3 (little-endian header field); 0 = place as-is.
- JOB_ID_W, 8, width of the job tag carried with each beat.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- job_valid  in  1  job offered
- job_ready  out  1  job accepted when job_valid && job_ready
- job_id_i  in  JOB_ID_W  job tag
- block1_i  in  512  first block, passed through unchanged
- tail_i  in  96  tail words 0..2 ([95:64] = word 0)
- nonce_start_i  in  32  first nonce, inclusive
- nonce_end_i  in  32  last nonce, inclusive
- flush  in  1  abandon current job
- out_valid  out  1  beat available
- out_ready  in  1  consumer accepts beat
- out_job_id  out  JOB_ID_W  tag of the beat
- block1_o  out  512  registered block1
- block2_o  out  NUM_LANES*512  lane k occupies [k*512 +: 512]
- nonce_base_o  out  32  nonce of lane 0 (unswapped)
- lane_mask_o  out  NUM_LANES  bit k = lane k holds an in-range nonce
- job_done  out  1  single-cycle pulse when the last beat is accepted

Behaviour:
- Reset (async, active-high) puts the FSM in IDLE and drives:
  - job_ready=1; out_valid=0; job_done=0.
  - All data registers, block outputs, out_job_id, nonce_base_o and lane_mask_o to 0.
- States:
  - IDLE: job_ready=1. A job handshake captures all inputs, sets base=nonce_start_i and goes to RUN. out_valid=1 from the next cycle; latency is 1 cycle.
  - RUN: job_ready=0, out_valid=1. On out_valid && out_ready:
    - if this is the last beat, pulse job_done and go to IDLE (out_valid=0 next cycle);
    - otherwise base += NUM_LANES.
- Last beat condition: base + NUM_LANES - 1 >= end, computed in 33 bits.
- Lane nonce: n_k = base + k, computed in 33 bits.
- lane_mask_o bit k = (n_k <= end) in 33-bit compare. This suppresses wrap: lanes past 0xFFFFFFFF are never valid.
- Block 2 contents for lane k:
  - word 0..2 = tail words;
  - word 3 = n_k[31:0], byte-swapped if NONCE_BSWAP;
  - word 4 = 32'h8000_0000;
  - word 15 = 32'h0000_0280;
  - all other words = 0.
  - Masked lanes still carry their computed word 3; consumers must ignore them via lane_mask_o.
- Word i occupies bits [511-32*i -: 32] of each lane.
- Stall: while out_valid && !out_ready, all outputs hold stable.
- block2_o is derived combinationally from registered base and tail (no extra pipeline stage), or registered with identical timing. The chosen form must keep the 1-cycle latency and the stable-under-stall rule.
- start > end: the job is still accepted and emits one beat with lane_mask_o=0, then job_done.
- end = 0xFFFFFFFF: the final beat has bits set only for nonces <= 0xFFFFFFFF; the base increment never wraps into a second pass.
- flush: highest priority after reset. Next state is IDLE and out_valid=0 next cycle, with no job_done pulse. A flush in the same cycle as a job handshake discards that job.
- job_valid in RUN is ignored (job_ready=0).
- Reset mid-job returns to IDLE immediately; no beat or job_done.

Decomposition:
- Shared package miner_pkg holds:
  - SHA_PAD_WORD = 32'h8000_0000; BTC_HDR_LEN_BITS = 32'h0000_0280;
  - word index constants: NONCE_WORD=3, PAD_WORD=4, LEN_WORD=15;
  - function bswap32.
- One combinational sub-module, miner_block2_fmt (tail + nonce -> 512-bit block), instantiated NUM_LANES times in a generate loop.

Test Plan:
- NUM_LANES=4, start=0x10, end=0x1F, out_ready=1 → 4 beats with bases 0x10,0x14,0x18,0x1C, all lane_mask=4'hF; job_done on the 4th accept; lane 2 of beat 1 word 3 = bswap(0x12)=0x12000000.
- start=0x10, end=0x12 → single beat, lane_mask=4'b0111, job_done on accept.
- start=0xFFFFFFFE, end=0xFFFFFFFF → one beat, lane_mask=4'b0011, no wrap beat, return to IDLE.
- Hold out_ready=0 for 5 cycles mid-job → block2_o, nonce_base_o and lane_mask_o unchanged; base resumes correctly after release.
- flush asserted during the 2nd beat of a 0..0xFF job → out_valid=0 next cycle, no job_done, job_ready=1; a new job is accepted with its tag on out_job_id.
- Assert rst mid-RUN → all outputs 0 and job_ready=1 asynchronously; tail=0xAABBCCDD_11223344_55667788 with NONCE_BSWAP=0 gives word 3 = raw nonce, word 4 = 0x80000000, word 15 = 0x280, words 5..14 = 0.
